vga_draw_arbiter: RTL and testbench

Shares the single VGA adapter plot port between several square-drawing requesters: the ball, the state-highlight square and the erase square. Each requester posts a base coordinate and colour. The arbiter grants one requester at a time in round-robin order, then sweeps a SIDE×SIDE pixel square onto `xout`/`yout`/`colourout`/`plot`. It sits between the graphics sources and the VGA adapter, and replaces direct multi-driver hookups of square drawers to the adapter.

---
 rtl/vga_draw_pkg.sv | 28 ++
 rtl/vga_draw_arbiter_rr_priority_pick.sv | 41 ++++
 rtl/vga_draw_arbiter.sv | 137 +++++++++++++
 tb/tb_vga_draw_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_draw_pkg : shared types and widths for the VGA square-draw arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package vga_draw_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } draw_state_e;

   localparam int X_W = 12;
   localparam int Y_W = 11;
   localparam int C_W = 3;

   localparam logic [C_W-1:0] BLACK = 3'b000;
   localparam logic [C_W-1:0] RED   = 3'b100;
   localparam logic [C_W-1:0] WHITE = 3'b111;

   // Index width for n requesters; never zero so a 1-bit index still exists.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_draw_arbiter_rr_priority_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_priority_pick : combinational round-robin picker starting at ptr
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_priority_pick
   import vga_draw_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            valid,
   output logic [IW-1:0]   winner
);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_idx;

   // Walk offsets from farthest to nearest so the closest request to ptr wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      w_sum  = '0;
      w_idx  = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         w_sum = {1'b0, ptr} + (IW+1)'(off);
         if (w_sum >= (IW+1)'(NREQ)) begin
            w_sum = w_sum - (IW+1)'(NREQ);
         end
         w_idx = w_sum[IW-1:0];
         if (req[w_idx]) begin
            valid  = 1'b1;
            winner = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_draw_arbiter : round-robin grant of square requesters onto one plot port
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_draw_arbiter
   import vga_draw_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int SIDE = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*(X_W-1)-1:0] req_x,
   input  logic [NREQ*Y_W-1:0]    req_y,
   input  logic [NREQ*C_W-1:0]    req_colour,
   input  logic                   stall,
   output logic [NREQ-1:0]        ack,
   output logic [NREQ-1:0]        done,
   output logic                   busy,
   output logic [X_W-1:0]         xout,
   output logic [Y_W-1:0]         yout,
   output logic [C_W-1:0]         colourout,
   output logic                   plot
);

   localparam int IW = idx_w(NREQ);
   localparam int SW = $clog2(SIDE);
   localparam int CW = 2 * SW;
   localparam logic [CW-1:0]   c_last_cnt = '1;
   localparam logic [NREQ-1:0] c_one      = NREQ'(1);
   localparam logic [IW-1:0]   c_last_idx = IW'(NREQ - 1);

   logic [X_W-2:0] w_x_arr [NREQ];
   logic [Y_W-1:0] w_y_arr [NREQ];
   logic [C_W-1:0] w_c_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_x_arr[gi] = req_x[gi*(X_W-1) +: (X_W-1)];
      assign w_y_arr[gi] = req_y[gi*Y_W +: Y_W];
      assign w_c_arr[gi] = req_colour[gi*C_W +: C_W];
   end

   draw_state_e    r_state;
   logic [IW-1:0]  r_ptr;
   logic [IW-1:0]  r_win;
   logic [CW-1:0]  r_cnt;
   logic [X_W-2:0] r_x;
   logic [Y_W-1:0] r_y;

   logic           w_valid;
   logic [IW-1:0]  w_winner;
   logic [CW-1:0]  w_cnt_nxt;
   logic [X_W-1:0] w_x_nxt;
   logic [Y_W-1:0] w_y_nxt;

   rr_priority_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .valid  (w_valid),
      .winner (w_winner)
   );

   // Low counter bits step x, high bits step y; x carries into bit 11, y wraps.
   assign w_cnt_nxt = r_cnt + 1'b1;
   assign w_x_nxt   = {1'b0, r_x} + {{(X_W-SW){1'b0}}, w_cnt_nxt[SW-1:0]};
   assign w_y_nxt   = r_y + {{(Y_W-SW){1'b0}}, w_cnt_nxt[CW-1:SW]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_win     <= '0;
         r_cnt     <= '0;
         r_x       <= '0;
         r_y       <= '0;
         ack       <= '0;
         done      <= '0;
         busy      <= 1'b0;
         xout      <= '0;
         yout      <= '0;
         colourout <= '0;
         plot      <= 1'b0;
      end else begin
         ack  <= '0;
         done <= '0;
         case (r_state)
            // DONE also grants so back-to-back squares are SIDE*SIDE+1 apart.
            IDLE, DONE: begin
               if (w_valid) begin
                  r_state   <= DRAW;
                  r_win     <= w_winner;
                  r_x       <= w_x_arr[w_winner];
                  r_y       <= w_y_arr[w_winner];
                  r_cnt     <= '0;
                  ack       <= c_one << w_winner;
                  busy      <= 1'b1;
                  xout      <= {1'b0, w_x_arr[w_winner]};
                  yout      <= w_y_arr[w_winner];
                  colourout <= w_c_arr[w_winner];
                  plot      <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
                  plot    <= 1'b0;
               end
            end
            DRAW: begin
               if (stall) begin
                  plot <= 1'b0;
               end else if (r_cnt == c_last_cnt) begin
                  r_state <= DONE;
                  plot    <= 1'b0;
                  done    <= c_one << r_win;
                  r_ptr   <= (r_win == c_last_idx) ? '0 : r_win + 1'b1;
               end else begin
                  r_cnt <= w_cnt_nxt;
                  xout  <= w_x_nxt;
                  yout  <= w_y_nxt;
                  plot  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
               plot    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_draw_arbiter : scoreboard bench for the round-robin square arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_vga_draw_arbiter;

   localparam int NREQ = 4;
   localparam int SIDE = 4;
   localparam int SS   = SIDE * SIDE;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*11-1:0] req_x = '0;
   logic [NREQ*11-1:0] req_y = '0;
   logic [NREQ*3-1:0] req_colour = '0;
   logic              stall = 1'b0;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [11:0]       xout;
   logic [10:0]       yout;
   logic [2:0]        colourout;
   logic              plot;

   vga_draw_arbiter #(
      .NREQ (NREQ),
      .SIDE (SIDE)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .stall      (stall),
      .ack        (ack),
      .done       (done),
      .busy       (busy),
      .xout       (xout),
      .yout       (yout),
      .colourout  (colourout),
      .plot       (plot)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int x;
      int y;
      int c;
   } sq_t;

   sq_t exp_q[$];
   sq_t init_v [NREQ];
   sq_t nxt_v  [NREQ][$];
   sq_t d_cur  [NREQ];
   sq_t d_nxt  [NREQ][$];
   sq_t m_cur  [NREQ];
   sq_t m_nxt  [NREQ][$];
   int  m_ptr = 0;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int mon_cyc  = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endfunction

   // Pixel k of a square: x steps fastest, y wraps at 2048, x never wraps.
   function automatic logic [63:0] exp_pix(input sq_t s, input int k);
      logic [11:0] xv;
      logic [10:0] yv;
      logic [2:0]  cv;
      xv = 12'(s.x + (k % SIDE));
      yv = 11'((s.y + (k / SIDE)) % 2048);
      cv = 3'(s.c);
      return {38'd0, xv, yv, cv};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   sq_t cur;
   bit  active = 1'b0;
   bit  prev_stall = 1'b0;
   int  pix = 0;
   int  ack_cyc = 0;
   int  nstall = 0;

   always @(negedge clk) begin
      mon_cyc++;
      if (!reset_n) begin
         active     = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (ack != '0) begin
            check("ack_onehot", $countones(ack), 1);
            if (exp_q.size() == 0) begin
               check("ack_unexpected", ack, 0);
            end else begin
               cur = exp_q.pop_front();
               check("ack_id", ack, 1 << cur.id);
               active     = 1'b1;
               pix        = 0;
               ack_cyc    = mon_cyc;
               nstall     = 0;
               prev_stall = 1'b0;
            end
         end
         if (active && done == '0) begin
            check("plot_strobe", plot, prev_stall ? 1'b0 : 1'b1);
         end
         if (plot) begin
            if (!active || pix >= SS) check("plot_extra", plot, 0);
            else check("pixel", {xout, yout, colourout}, exp_pix(cur, pix));
            pix++;
         end
         if (done != '0) begin
            check("done_id", done, active ? (1 << cur.id) : 0);
            check("done_pixels", pix, SS);
            check("done_latency", mon_cyc - ack_cyc, SS + nstall);
            check("done_busy", busy, 1);
            check("done_plot", plot, 0);
            active = 1'b0;
            done_cnt++;
         end else if (active) begin
            nstall += int'(stall);
         end
         prev_stall = active ? stall : 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         req_x[i*11 +: 11]     = 11'(d_cur[i].x);
         req_y[i*11 +: 11]     = 11'(d_cur[i].y);
         req_colour[i*3 +: 3]  = 3'(d_cur[i].c);
      end
   endtask

   task automatic clear_lists();
      for (int i = 0; i < NREQ; i++) begin
         init_v[i] = '{id: i, x: 0, y: 0, c: 0};
         nxt_v[i].delete();
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      stall   = 1'b0;
      exp_q.delete();
      m_ptr   = 0;
      clear_lists();
      step();
      step();
      check("reset_outputs", {ack, done, busy, xout, yout, colourout, plot}, 0);
      reset_n = 1'b1;
   endtask

   function automatic logic stall_val(input int smode, input int since,
                                      input int s_at, input int s_len);
      if (smode == 1) return (since >= s_at - 1) && (since < s_at - 1 + s_len);
      if (smode == 2) return ($urandom_range(0, 3) == 0);
      return 1'b0;
   endfunction

   // Requesters in mask hold req; each switches to its next value set after its ack.
   task automatic run(input logic [NREQ-1:0] mask, input int n, input int smode,
                      input int s_at, input int s_len, input bit chk_gap);
      int grants, since, last_ack, base, w, idx;
      sq_t sq;
      for (int i = 0; i < NREQ; i++) begin
         m_cur[i] = init_v[i];
         m_nxt[i] = nxt_v[i];
         d_cur[i] = init_v[i];
         d_nxt[i] = nxt_v[i];
      end
      for (int g = 0; g < n; g++) begin
         w = -1;
         for (int off = 0; off < NREQ; off++) begin
            idx = (m_ptr + off) % NREQ;
            if (w < 0 && mask[2'(idx)]) w = idx;
         end
         sq    = m_cur[w];
         sq.id = w;
         exp_q.push_back(sq);
         if (m_nxt[w].size() > 0) m_cur[w] = m_nxt[w].pop_front();
         m_ptr = (w + 1) % NREQ;
      end

      base     = done_cnt;
      grants   = 0;
      since    = 0;
      last_ack = 0;
      apply();
      req   = mask;
      stall = 1'b0;
      for (int cyc = 0; cyc < n * (4 * SS + 8) + 20 && grants < n; cyc++) begin
         step();
         if (ack != '0) begin
            if (chk_gap && grants > 0) check("grant_period", cyc - last_ack, SS + 1);
            last_ack = cyc;
            since    = 0;
            for (int i = 0; i < NREQ; i++) begin
               if (ack[i]) begin
                  grants++;
                  if (d_nxt[i].size() > 0) d_cur[i] = d_nxt[i].pop_front();
               end
            end
            apply();
            if (grants >= n) req = '0;
         end else begin
            since++;
         end
         stall = stall_val(smode, since, s_at, s_len);
      end
      req = '0;
      check("grants", grants, n);
      for (int cyc = 0; cyc < 4 * SS + 40 && done_cnt < base + n; cyc++) begin
         step();
         since++;
         stall = stall_val(smode, since, s_at, s_len);
      end
      stall = 1'b0;
      check("squares_done", done_cnt - base, n);
      step();
      step();
      check("idle_after", {busy, plot, ack}, 0);
   endtask

   initial begin
      int got;
      int nn;

      // Single square from requester 0.
      do_reset();
      init_v[0] = '{id: 0, x: 148, y: 18, c: 4};
      run(4'b0001, 1, 0, 0, 0, 1'b0);

      // All requesting: 0,1,2,3,0 at SS+1 spacing.
      do_reset();
      for (int i = 0; i < NREQ; i++) init_v[i] = '{id: i, x: i * 40 + 5, y: i * 30 + 2, c: i + 1};
      run(4'b1111, 5, 0, 0, 0, 1'b1);

      // Three stall cycles starting at pixel 5.
      do_reset();
      init_v[0] = '{id: 0, x: 10, y: 10, c: 2};
      run(4'b0001, 1, 1, 5, 3, 1'b0);

      // y wrap and x carry into bit 11.
      do_reset();
      init_v[2] = '{id: 2, x: 2047, y: 2046, c: 5};
      run(4'b0100, 1, 0, 0, 0, 1'b0);

      // Reset in the middle of a sweep.
      do_reset();
      d_cur[0] = '{id: 0, x: 100, y: 50, c: 7};
      for (int i = 1; i < NREQ; i++) d_cur[i] = '{id: i, x: 0, y: 0, c: 0};
      apply();
      exp_q.push_back(d_cur[0]);
      req = 4'b0001;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         step();
         if (ack[0]) got = 1;
      end
      check("rst_ack", got, 1);
      req = '0;
      repeat (7) step();
      check("rst_pixel7", {xout, yout, colourout}, exp_pix(d_cur[0], 7));
      reset_n = 1'b0;
      exp_q.delete();
      step();
      check("rst_mid_outputs", {ack, done, busy, xout, yout, colourout, plot}, 0);
      repeat (2) step();
      reset_n = 1'b1;
      m_ptr = 0;
      clear_lists();
      init_v[1] = '{id: 1, x: 400, y: 300, c: 3};
      run(4'b0010, 1, 0, 0, 0, 1'b0);

      // Colour and position change right after ack; used only at next grant.
      do_reset();
      init_v[0] = '{id: 0, x: 300, y: 200, c: 4};
      nxt_v[0].push_back('{id: 0, x: 301, y: 201, c: 1});
      run(4'b0001, 2, 0, 0, 0, 1'b1);

      // Randomized masks, coordinates and stall.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < NREQ; i++) begin
            init_v[i] = '{id: i, x: int'($urandom_range(0, 2047)),
                          y: int'($urandom_range(0, 2047)), c: int'($urandom_range(0, 7))};
            nn = int'($urandom_range(0, 2));
            for (int k = 0; k < nn; k++) begin
               nxt_v[i].push_back('{id: i, x: int'($urandom_range(0, 2047)),
                                    y: int'($urandom_range(0, 2047)), c: int'($urandom_range(0, 7))});
            end
         end
         run(4'($urandom_range(1, 15)), 6, 2, 0, 0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
